// File: rtl/rv_mem_arb.sv
// rv_mem_arb: shares one fixed-latency single-port memory
// between NPORTS requestors, one transaction at a time.
module rv_mem_arb #(
    parameter int DPWIDTH  = 32,
    parameter int NPORTS   = 2,
    parameter int MEM_LAT  = 2,
    parameter int ARB_MODE = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NPORTS-1:0]           req,
    input  logic [NPORTS-1:0]           we,
    input  logic [NPORTS*DPWIDTH-1:0]   addr,
    input  logic [NPORTS*DPWIDTH-1:0]   wdata,
    output logic [NPORTS-1:0]           gnt,
    output logic [NPORTS-1:0]           rvalid,
    output logic [DPWIDTH-1:0]          rdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [DPWIDTH-1:0]          mem_addr,
    output logic [DPWIDTH-1:0]          mem_wdata,
    input  logic [DPWIDTH-1:0]          mem_rdata
);

    localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int CW = $clog2(MEM_LAT + 2);
    localparam logic [CW-1:0] LAT_C = CW'(MEM_LAT);
    localparam logic [IW-1:0] LAST_RST = IW'(NPORTS - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [IW-1:0]        last_q, last_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DPWIDTH-1:0]   rdata_q, rdata_d;

    logic                 win_vld;
    logic [IW-1:0]        win;
    logic [IW-1:0]        idx;

    assign rdata = rdata_q;

    // Winner selection: rotate from last grant, or lowest index wins.
    always_comb begin
        win_vld = 1'b0;
        win     = '0;
        idx     = '0;
        if (ARB_MODE == 1) begin
            for (int i = NPORTS - 1; i >= 0; i--) begin
                if (req[i]) begin
                    win_vld = 1'b1;
                    win     = IW'(i);
                end
            end
        end else begin
            for (int off = 1; off <= NPORTS; off++) begin
                idx = IW'((int'(last_q) + off) % NPORTS);
                if (!win_vld && req[idx]) begin
                    win_vld = 1'b1;
                    win     = idx;
                end
            end
        end
    end

    // Next state and outputs; everything is quiet while rst is high.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        gnt       = '0;
        rvalid    = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    gnt[win]  = 1'b1;
                    mem_en    = 1'b1;
                    mem_we    = we[win];
                    mem_addr  = addr[int'(win)*DPWIDTH +: DPWIDTH];
                    mem_wdata = wdata[int'(win)*DPWIDTH +: DPWIDTH];
                    owner_d   = win;
                    last_d    = win;
                    cnt_d     = CW'(1);
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAT_C) begin
                    rdata_d = mem_rdata;
                    state_d = RESP;
                end
            end
            RESP: begin
                rvalid[owner_q] = 1'b1;
                cnt_d           = '0;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            gnt       = '0;
            rvalid    = '0;
            mem_en    = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_rv_mem_arb.sv
// tb_rv_mem_arb: directed tests on two arbiter configurations
// against a transaction-level model of the memory arbiter.
module tb_rv_mem_arb;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req[2];
    logic [3:0]   we[2];
    logic [127:0] addr[2];
    logic [127:0] wdata[2];
    logic [3:0]   gnt[2];
    logic [3:0]   rvalid[2];
    logic [31:0]  rdata[2];
    logic         mem_en[2];
    logic         mem_we[2];
    logic [31:0]  mem_addr[2];
    logic [31:0]  mem_wdata[2];
    logic [31:0]  mem_rdata[2];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    bit en_chk = 0;

    always #5 clk = ~clk;

    rv_mem_arb #(.DPWIDTH(32), .NPORTS(4), .MEM_LAT(2), .ARB_MODE(0)) u_a (
        .clk(clk), .rst(rst), .req(req[0]), .we(we[0]),
        .addr(addr[0]), .wdata(wdata[0]), .gnt(gnt[0]),
        .rvalid(rvalid[0]), .rdata(rdata[0]), .mem_en(mem_en[0]),
        .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
    );

    rv_mem_arb #(.DPWIDTH(32), .NPORTS(4), .MEM_LAT(1), .ARB_MODE(1)) u_b (
        .clk(clk), .rst(rst), .req(req[1]), .we(we[1]),
        .addr(addr[1]), .wdata(wdata[1]), .gnt(gnt[1]),
        .rvalid(rvalid[1]), .rdata(rdata[1]), .mem_en(mem_en[1]),
        .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
    );

    // Fixed-latency memories: read data appears exactly MEM_LAT
    // cycles after the access, and is zero otherwise.
    logic [31:0] bmem[2][1024];
    logic [31:0] p1[2];
    logic [31:0] p2;
    bit mem_init = 0;

    assign mem_rdata[0] = p2;
    assign mem_rdata[1] = p1[1];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        p2 <= p1[0];
        for (int k = 0; k < 2; k++) begin
            p1[k] <= mem_en[k] ? bmem[k][mem_addr[k][11:2]] : 32'h0;
            if (mem_en[k] && mem_we[k])
                bmem[k][mem_addr[k][11:2]] <= mem_wdata[k];
        end
        if (!mem_init) begin
            for (int k = 0; k < 2; k++)
                for (int i = 0; i < 1024; i++)
                    bmem[k][i] <= 32'h0;
            bmem[0][64] <= 32'hDEADBEEF;
            bmem[1][32] <= 32'hCAFEF00D;
            mem_init <= 1'b1;
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int lat_of(int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic int pick(logic [3:0] r, int last, bit fixed);
        if (fixed) begin
            for (int i = 0; i < 4; i++)
                if (r[i]) return i;
            return -1;
        end
        for (int o = 1; o <= 4; o++)
            if (r[(last + o) % 4]) return (last + o) % 4;
        return -1;
    endfunction

    // Transaction-level model: one access in flight, answered
    // lat+1 cycles after its grant with the memory word as it was
    // when granted.
    bit          m_busy[2];
    int          m_cnt[2];
    int          m_own[2];
    int          m_last[2];
    logic [31:0] m_pend[2];
    logic [31:0] m_rd[2];
    logic [31:0] mm[2][1024];

    initial begin
        logic [3:0]  eg, ev;
        logic        een, ewe;
        logic [31:0] ea, ed;
        int          w;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 1024; i++) mm[k][i] = 32'h0;
            m_busy[k] = 0; m_cnt[k] = 0; m_own[k] = 0;
            m_last[k] = 3; m_pend[k] = 0; m_rd[k] = 0;
        end
        mm[0][64] = 32'hDEADBEEF;
        mm[1][32] = 32'hCAFEF00D;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                eg = 0; ev = 0; een = 0; ewe = 0; ea = 0; ed = 0;
                w = -1;
                if (!rst) begin
                    if (!m_busy[k]) w = pick(req[k], m_last[k], k == 1);
                    if (w >= 0) begin
                        eg[w] = 1'b1;
                        een   = 1'b1;
                        ewe   = we[k][w];
                        ea    = addr[k][w*32 +: 32];
                        ed    = wdata[k][w*32 +: 32];
                    end
                    if (m_busy[k] && m_cnt[k] == lat_of(k) + 1)
                        ev[m_own[k]] = 1'b1;
                end
                if (en_chk) begin
                    chk($sformatf("m%0d.gnt", k), 32'(gnt[k]), 32'(eg));
                    chk($sformatf("m%0d.rvalid", k), 32'(rvalid[k]), 32'(ev));
                    chk($sformatf("m%0d.mem_en", k), 32'(mem_en[k]), 32'(een));
                    chk($sformatf("m%0d.mem_we", k), 32'(mem_we[k]), 32'(ewe));
                    chk($sformatf("m%0d.mem_addr", k), mem_addr[k], ea);
                    chk($sformatf("m%0d.mem_wdata", k), mem_wdata[k], ed);
                    chk($sformatf("m%0d.rdata", k), rdata[k], m_rd[k]);
                end
                if (rst) begin
                    m_busy[k] = 0;
                    m_last[k] = 3;
                    m_rd[k]   = 0;
                end else if (w >= 0) begin
                    m_busy[k] = 1;
                    m_cnt[k]  = 1;
                    m_own[k]  = w;
                    m_last[k] = w;
                    m_pend[k] = mm[k][ea[11:2]];
                    if (ewe) mm[k][ea[11:2]] = ed;
                end else if (m_busy[k]) begin
                    if (m_cnt[k] == lat_of(k) + 1) begin
                        m_busy[k] = 0;
                    end else begin
                        if (m_cnt[k] == lat_of(k)) m_rd[k] = m_pend[k];
                        m_cnt[k]++;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(int k, int p, bit r, bit w,
                            logic [31:0] a, logic [31:0] d);
        req[k][p] = r;
        we[k][p] = w;
        addr[k][p*32 +: 32] = a;
        wdata[k][p*32 +: 32] = d;
    endtask

    task automatic wait_gnt(int k, int maxc, output int port, output int c);
        port = -1;
        c = -1;
        for (int i = 0; i < maxc && port < 0; i++) begin
            @(negedge clk);
            for (int j = 0; j < 4; j++)
                if (gnt[k][j]) begin port = j; c = cyc; end
        end
        if (port < 0) begin
            n_chk++; n_fail++;
            $display("FAIL gnt_timeout: inst %0d got no grant, expected one", k);
        end
    endtask

    task automatic wait_rv(int k, int maxc, output int port, output int c);
        port = -1;
        c = -1;
        for (int i = 0; i < maxc && port < 0; i++) begin
            @(negedge clk);
            for (int j = 0; j < 4; j++)
                if (rvalid[k][j]) begin port = j; c = cyc; end
        end
        if (port < 0) begin
            n_chk++; n_fail++;
            $display("FAIL rv_timeout: inst %0d got no rvalid, expected one", k);
        end
    endtask

    initial begin
        int p, t, t2, tp;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req[k] = 0; we[k] = 0; addr[k] = 0; wdata[k] = 0;
        end
        tick();
        tick();
        rst = 1'b0;
        en_chk = 1'b1;
        @(negedge clk);
        chk("rst.gnt", 32'(gnt[0]), 0);
        chk("rst.rvalid", 32'(rvalid[0]), 0);
        chk("rst.mem_en", 32'(mem_en[0]), 0);
        chk("rst.rdata", rdata[0], 0);

        // single read from port 0
        tick();
        set_port(0, 0, 1, 0, 32'h100, 0);
        wait_gnt(0, 10, p, t);
        chk("rd.port", p, 0);
        chk("rd.mem_en", 32'(mem_en[0]), 1);
        chk("rd.mem_addr", mem_addr[0], 32'h100);
        tick();
        set_port(0, 0, 0, 0, 0, 0);
        wait_rv(0, 10, p, t2);
        chk("rd.rv_port", p, 0);
        chk("rd.latency", t2 - t, 3);
        chk("rd.rdata", rdata[0], 32'hDEADBEEF);

        // write then read on port 1
        tick();
        set_port(0, 1, 1, 1, 32'h40, 32'h12345678);
        wait_gnt(0, 10, p, t);
        chk("wr.port", p, 1);
        chk("wr.mem_we", 32'(mem_we[0]), 1);
        chk("wr.mem_wdata", mem_wdata[0], 32'h12345678);
        tick();
        set_port(0, 1, 0, 0, 0, 0);
        wait_rv(0, 10, p, t2);
        chk("wr.rv_port", p, 1);
        chk("wr.latency", t2 - t, 3);
        tick();
        set_port(0, 1, 1, 0, 32'h40, 0);
        wait_gnt(0, 10, p, t);
        tick();
        set_port(0, 1, 0, 0, 0, 0);
        wait_rv(0, 10, p, t2);
        chk("rb.rdata", rdata[0], 32'h12345678);

        // round-robin with all four ports requesting
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_port(0, 0, 1, 0, 32'h100, 0);
        for (int i = 1; i < 4; i++) set_port(0, i, 1, 0, 32'(i * 4), 0);
        tp = 0;
        for (int g = 0; g < 5; g++) begin
            wait_gnt(0, 10, p, t);
            chk($sformatf("rr.order%0d", g), p, g % 4);
            if (g > 0) chk($sformatf("rr.space%0d", g), t - tp, 4);
            tp = t;
        end
        tick();
        for (int i = 0; i < 4; i++) set_port(0, i, 0, 0, 0, 0);
        wait_rv(0, 10, p, t2);
        chk("rr.rdata", rdata[0], 32'hDEADBEEF);

        // reset one cycle after a grant to port 1
        tick();
        set_port(0, 1, 1, 0, 32'h40, 0);
        wait_gnt(0, 10, p, t);
        chk("mr.port", p, 1);
        tick();
        rst = 1'b1;
        set_port(0, 0, 1, 0, 32'h100, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mr.rvalid", 32'(rvalid[0]), 0);
        chk("mr.rdata", rdata[0], 0);
        chk("mr.gnt", 32'(gnt[0]), 32'h1);
        chk("mr.when", cyc - t, 2);
        tick();
        set_port(0, 0, 0, 0, 0, 0);
        wait_gnt(0, 10, p, t2);
        chk("mr.regnt", p, 1);
        chk("mr.regnt_when", t2 - t, 6);
        tick();
        set_port(0, 1, 0, 0, 0, 0);
        wait_rv(0, 10, p, t2);
        chk("mr.rv_port", p, 1);
        chk("mr.rdata2", rdata[0], 32'h12345678);

        // fixed priority, MEM_LAT = 1
        tick();
        set_port(1, 0, 1, 0, 32'h0, 0);
        set_port(1, 2, 1, 0, 32'h8, 0);
        tp = 0;
        for (int g = 0; g < 3; g++) begin
            wait_gnt(1, 10, p, t);
            chk($sformatf("fp.port%0d", g), p, 0);
            if (g > 0) chk($sformatf("fp.space%0d", g), t - tp, 3);
            tp = t;
        end
        tick();
        set_port(1, 0, 0, 0, 0, 0);
        wait_gnt(1, 10, p, t);
        chk("fp.port2", p, 2);
        chk("fp.space2", t - tp, 3);

        // port 0 withdraws before grant while port 1 holds
        tick();
        set_port(1, 2, 0, 0, 0, 0);
        set_port(1, 0, 1, 0, 32'h0, 0);
        set_port(1, 1, 1, 0, 32'h80, 0);
        tick();
        set_port(1, 0, 0, 0, 0, 0);
        wait_gnt(1, 10, p, tp);
        chk("wd.port", p, 1);
        chk("wd.when", tp - t, 3);
        tick();
        set_port(1, 1, 0, 0, 0, 0);
        wait_rv(1, 10, p, t2);
        chk("wd.rv_port", p, 1);
        chk("wd.latency", t2 - tp, 2);
        chk("wd.rdata", rdata[1], 32'hCAFEF00D);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
